fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the async FIFO write port between NREQ requesters.

---
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares the async FIFO write port among NREQ requesters, one burst per grant.
// Latency: one IDLE arbitration cycle per grant, after which beats pass combinationally to w_en/wdata.
// Backpressure: wfull holds off req_ready/w_en and freezes the burst; a granted requester that stalls is dropped after IDLE_TMO cycles.
//
// Ports:
//   wclk, wrst            write clock, synchronous active-high reset
//   req_valid/data/last   per-requester beat offer (data lane i at [i*DATASIZE +: DATASIZE])
//   req_ready             per-requester accept strobe (only the granted bit can be high)
//   wfull                 FIFO full from the write-pointer logic
//   w_en, wdata           write strobe and beat toward fifo_memory
//   grant_id, busy        current grant index, high while a burst is open
module fifo_wr_arbiter #(
    parameter  int DATASIZE = 64,
    parameter  int NREQ     = 4,
    parameter  int MAXBURST = 8,
    parameter  int IDLE_TMO = 16,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     w_en,
    output logic [DATASIZE-1:0]      wdata,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy
);

    localparam int BCW = $clog2(MAXBURST + 1);
    localparam int SCW = $clog2(IDLE_TMO + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t         state_q,     state_d;
    logic [IDW-1:0] rr_last_q,   rr_last_d;
    logic [IDW-1:0] grant_id_q,  grant_id_d;
    logic [BCW-1:0] beat_cnt_q,  beat_cnt_d;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

    logic           found;
    logic [IDW-1:0] pick;
    logic           accept;

    // A beat moves only when the granted requester offers one and the FIFO has room.
    assign accept = (state_q == ST_BURST) && req_valid[grant_id_q] && !wfull;

    // Round-robin search starting one past the last requester served.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_last_q) + 1 + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= IDW'(NREQ - 1);
            grant_id_q  <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            grant_id_q  <= grant_id_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        grant_id_d  = grant_id_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_id_d  = pick;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (accept) begin
                    beat_cnt_d  = beat_cnt_q + 1'b1;
                    stall_cnt_d = '0;
                    if (req_last[grant_id_q] || beat_cnt_q == BCW'(MAXBURST - 1)) begin
                        // Clear on release so beat_cnt stays within MAXBURST-1.
                        beat_cnt_d = '0;
                        rr_last_d  = grant_id_q;
                        state_d    = ST_IDLE;
                    end
                end else if (!req_valid[grant_id_q]) begin
                    // A stalled requester is dropped on its IDLE_TMO-th consecutive empty cycle.
                    if (stall_cnt_q == SCW'(IDLE_TMO - 1)) begin
                        rr_last_d = grant_id_q;
                        state_d   = ST_IDLE;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end
                // valid with wfull: hold everything.
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (state_q == ST_BURST) begin
            busy                  = 1'b1;
            req_ready[grant_id_q] = !wfull;
        end
    end

    assign w_en     = accept;
    assign wdata    = req_data[int'(grant_id_q)*DATASIZE +: DATASIZE];
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int DW = 16;
    localparam int NR = 4;

    logic             clk;
    logic             wrst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             wfull;
    logic             w_en;
    logic [DW-1:0]    wdata;
    logic [1:0]       grant_id;
    logic             busy;

    int total;
    int bad;

    fifo_wr_arbiter #(
        .DATASIZE(DW),
        .NREQ    (NR),
        .MAXBURST(4),
        .IDLE_TMO(16)
    ) dut (
        .wclk     (clk),
        .wrst     (wrst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .wfull    (wfull),
        .w_en     (w_en),
        .wdata    (wdata),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] lst;
        logic       full;
        logic [11:0] dat;
        logic [3:0] e_rdy;
        logic       e_wen;
        logic       e_busy;
        logic [1:0] e_gnt;
    } vec_t;

    vec_t vt[25];

    // Lane i carries {dat, i} so wdata also reveals which lane the mux picked.
    task automatic set_lanes(input logic [11:0] d);
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {d, 4'(i)};
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic f, input logic [11:0] d);
        wrst      = r;
        req_valid = v;
        req_last  = l;
        wfull     = f;
        set_lanes(d);
    endtask

    task automatic inv_check(input string name);
        total++;
        if ((w_en && wfull) || ($countones(req_ready) > 1)) begin
            bad++;
            $display("FAIL %s invariant: w_en=%b wfull=%b req_ready=%b, required no write while full and at most one ready",
                     name, w_en, wfull, req_ready);
        end
    endtask

    task automatic chk(input string name, input logic [3:0] rdy, input logic wen,
                       input logic bsy, input logic [1:0] gnt, input logic [11:0] d);
        logic [DW-1:0] wd;
        wd = {d, 2'b00, gnt};
        total++;
        if ({req_ready, w_en, busy, grant_id} !== {rdy, wen, bsy, gnt}) begin
            bad++;
            $display("FAIL %s: got rdy=%b w_en=%b busy=%b gnt=%0d, want rdy=%b w_en=%b busy=%b gnt=%0d",
                     name, req_ready, w_en, busy, grant_id, rdy, wen, bsy, gnt);
        end
        if (wen) begin
            total++;
            if (wdata !== wd) begin
                bad++;
                $display("FAIL %s wdata: got %h want %h", name, wdata, wd);
            end
        end
        inv_check(name);
    endtask

    // One clock: drive after the edge, compare at the falling edge.
    task automatic cyc(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f,
                       input logic [11:0] d, input string name, input logic [3:0] rdy,
                       input logic wen, input logic bsy, input logic [1:0] gnt);
        drive(r, v, l, f, d);
        @(negedge clk);
        chk(name, rdy, wen, bsy, gnt, d);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cycle();
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 12'h000);
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] wr_q[$];
    logic [DW-1:0] exp3[7];
    int  b1, stalls;
    bit  d3, acc1, acc3, seen_idle;

    initial begin
        total = 0;
        bad   = 0;

        //        rst   vld      lst      full  dat      e_rdy    wen   busy  gnt
        vt[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vt[1]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vt[2]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 12'h0A1, 4'b0001, 1'b1, 1'b1, 2'd0};
        vt[3]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 12'h0B1, 4'b0001, 1'b1, 1'b1, 2'd0};
        vt[4]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 12'h0C1, 4'b0001, 1'b1, 1'b1, 2'd0};
        vt[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vt[6]  = '{1'b1, 4'b0101, 4'b0101, 1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vt[7]  = '{1'b0, 4'b0101, 4'b0101, 1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vt[8]  = '{1'b0, 4'b0101, 4'b0101, 1'b0, 12'h021, 4'b0001, 1'b1, 1'b1, 2'd0};
        vt[9]  = '{1'b0, 4'b0101, 4'b0101, 1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vt[10] = '{1'b0, 4'b0101, 4'b0101, 1'b0, 12'h022, 4'b0100, 1'b1, 1'b1, 2'd2};
        vt[11] = '{1'b0, 4'b0101, 4'b0101, 1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 2'd2};
        vt[12] = '{1'b0, 4'b0101, 4'b0101, 1'b0, 12'h023, 4'b0001, 1'b1, 1'b1, 2'd0};
        vt[13] = '{1'b0, 4'b0101, 4'b0101, 1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vt[14] = '{1'b0, 4'b0101, 4'b0101, 1'b0, 12'h024, 4'b0100, 1'b1, 1'b1, 2'd2};
        vt[15] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 2'd2};
        vt[16] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 12'h101, 4'b0010, 1'b1, 1'b1, 2'd1};
        vt[17] = '{1'b0, 4'b0010, 4'b0000, 1'b1, 12'h102, 4'b0000, 1'b0, 1'b1, 2'd1};
        vt[18] = '{1'b0, 4'b0010, 4'b0000, 1'b1, 12'h102, 4'b0000, 1'b0, 1'b1, 2'd1};
        vt[19] = '{1'b0, 4'b0010, 4'b0000, 1'b1, 12'h102, 4'b0000, 1'b0, 1'b1, 2'd1};
        vt[20] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 12'h102, 4'b0010, 1'b1, 1'b1, 2'd1};
        vt[21] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 12'h103, 4'b0010, 1'b1, 1'b1, 2'd1};
        vt[22] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 12'h104, 4'b0010, 1'b1, 1'b1, 2'd1};
        vt[23] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 12'h000, 4'b0000, 1'b0, 1'b0, 2'd1};
        vt[24] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 12'h000, 4'b0000, 1'b0, 1'b1, 2'd1};

        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 12'h000);
        @(posedge clk);
        @(posedge clk);
        #1;

        // Single burst, alternating 1-beat grants, wfull hold and MAXBURST release.
        for (int i = 0; i < 25; i++) begin
            cyc(vt[i].rst, vt[i].vld, vt[i].lst, vt[i].full, vt[i].dat,
                $sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_wen, vt[i].e_busy, vt[i].e_gnt);
        end

        // Requester 1 streams 6 beats against MAXBURST=4 while requester 3 waits.
        rst_cycle();
        b1 = 1;
        d3 = 1'b0;
        for (int c = 0; c < 40 && (b1 <= 6 || !d3); c++) begin
            wrst      = 1'b0;
            wfull     = 1'b0;
            req_valid = {!d3, 1'b0, (b1 <= 6), 1'b0};
            req_last  = {1'b1, 1'b0, (b1 == 6), 1'b0};
            req_data  = '0;
            req_data[1*DW +: DW] = 16'h0100 + 16'(b1);
            req_data[3*DW +: DW] = 16'h0300;
            @(negedge clk);
            inv_check("t3");
            if (w_en) wr_q.push_back(wdata);
            acc1 = req_ready[1] && req_valid[1];
            acc3 = req_ready[3] && req_valid[3];
            @(posedge clk);
            #1;
            if (acc1) b1++;
            if (acc3) d3 = 1'b1;
        end
        exp3 = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0300, 16'h0105, 16'h0106};
        total++;
        if (wr_q.size() != 7) begin
            bad++;
            $display("FAIL t3 write count: got %0d want 7", wr_q.size());
        end
        for (int i = 0; i < 7 && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i] !== exp3[i]) begin
                bad++;
                $display("FAIL t3 write %0d: got %h want %h", i, wr_q[i], exp3[i]);
            end
        end

        // Granted requester goes quiet after one beat: released after 16 stalled cycles.
        rst_cycle();
        cyc(1'b0, 4'b0100, 4'b0000, 1'b0, 12'h051, "t5a", 4'b0000, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 4'b0100, 4'b0000, 1'b0, 12'h052, "t5b", 4'b0100, 1'b1, 1'b1, 2'd2);
        drive(1'b0, 4'b1010, 4'b1010, 1'b0, 12'h053);
        stalls    = 0;
        seen_idle = 1'b0;
        for (int c = 0; c < 40 && !seen_idle; c++) begin
            @(negedge clk);
            inv_check("t5 stall");
            if (busy && grant_id == 2'd2 && !w_en) stalls++;
            else seen_idle = 1'b1;
            if (!seen_idle) begin
                @(posedge clk);
                #1;
            end
        end
        total++;
        if (!seen_idle || stalls != 16 || busy !== 1'b0) begin
            bad++;
            $display("FAIL t5 timeout: got stalls=%0d idle=%0b busy=%b want stalls=16 idle=1 busy=0",
                     stalls, seen_idle, busy);
        end
        @(posedge clk);
        #1;
        // rr_last=2 after release, so requester 3 wins over requester 1.
        cyc(1'b0, 4'b1010, 4'b1010, 1'b0, 12'h053, "t5next", 4'b1000, 1'b1, 1'b1, 2'd3);

        // Reset in the middle of a burst restarts the rotation at requester 0.
        rst_cycle();
        cyc(1'b0, 4'b0010, 4'b0010, 1'b0, 12'h061, "t6a", 4'b0000, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 4'b0010, 4'b0010, 1'b0, 12'h062, "t6b", 4'b0010, 1'b1, 1'b1, 2'd1);
        cyc(1'b0, 4'b0010, 4'b0000, 1'b0, 12'h063, "t6c", 4'b0000, 1'b0, 1'b0, 2'd1);
        cyc(1'b0, 4'b0010, 4'b0000, 1'b0, 12'h064, "t6d", 4'b0010, 1'b1, 1'b1, 2'd1);
        cyc(1'b0, 4'b0010, 4'b0000, 1'b0, 12'h065, "t6e", 4'b0010, 1'b1, 1'b1, 2'd1);
        cyc(1'b1, 4'b0010, 4'b0000, 1'b0, 12'h066, "t6f", 4'b0010, 1'b1, 1'b1, 2'd1);
        cyc(1'b0, 4'b1011, 4'b0000, 1'b0, 12'h067, "t6g", 4'b0000, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 4'b1011, 4'b0000, 1'b0, 12'h068, "t6h", 4'b0001, 1'b1, 1'b1, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
